aes_cipher_iter: RTL and testbench

Iterative AES encryption engine that consumes the expanded key schedule produced by `Key_Expansion`. It processes one 128-bit plaintext block per transaction and computes one round per clock cycle. The block sits directly downstream of key expansion in the cipher datapath. Valid/ready handshakes on input and output let it stall against neighbouring stages.

---
 rtl/aes_pkg.sv | 45 ++++
 rtl/aes_round.sv | 37 +++
 rtl/aes_cipher_iter.sv | 121 ++++++++++++
 tb/tb_aes_cipher_iter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, GF(2^8) helpers, round count and FSM state type.
package aes_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    // Forward S-box, entry 0 leftmost
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int unsigned aes_nr(input int unsigned nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns, AddRoundKey.
module aes_round
    import aes_pkg::*;
(
    input  logic [BLOCK_W-1:0] state,
    input  logic [BLOCK_W-1:0] round_key,
    input  logic               final_round,
    output logic [BLOCK_W-1:0] next_state
);

    logic [7:0] sb [16];
    logic [7:0] sr [16];
    logic [7:0] mc [16];

    // Byte i is column i/4, row i%4; byte 0 sits in the MSBs
    always_comb begin
        next_state = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(state[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c+0] = xtime(sr[4*c+0]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+1] = sr[4*c+0] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
            mc[4*c+2] = sr[4*c+0] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
            mc[4*c+3] = xtime(sr[4*c+0]) ^ sr[4*c+0] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
        end
        for (int i = 0; i < 16; i++) begin
            next_state[127-8*i -: 8] = (final_round ? sr[i] : mc[i]) ^ round_key[127-8*i -: 8];
        end
    end

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryptor, one round per clock, valid/ready on both sides.
// Define AES_KEY_REG_EN to capture round_keys at acceptance instead of reading them live.
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [0:127]                    in_block,
    input  logic [0:128*(aes_nr(NK)+1)-1]   round_keys,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [0:127]                    out_block
);

    localparam int unsigned NR    = aes_nr(NK);
    localparam int unsigned KEY_W = 128 * (NR + 1);
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(NR);

    aes_state_e          fsm_q, fsm_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BLOCK_W-1:0]  st_q, st_d;
    logic [BLOCK_W-1:0]  ob_q, ob_d;
    logic                ov_q, ov_d;
    logic                accept;
    logic                final_round;
    logic [BLOCK_W-1:0]  round_out;
    logic [0:KEY_W-1]    keys;
    logic [BLOCK_W-1:0]  rk [NR+1];

    assign in_ready = (fsm_q == IDLE) || ((fsm_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;

`ifdef AES_KEY_REG_EN
    logic [0:KEY_W-1] key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
        end else if (accept) begin
            key_q <= round_keys;
        end
    end

    assign keys = key_q;
`else
    assign keys = round_keys;
`endif

    always_comb begin
        for (int r = 0; r <= NR; r++) begin
            rk[r] = keys[128*r +: 128];
        end
    end

    assign final_round = (cnt_q == LAST_ROUND);

    aes_round u_round (
        .state       (st_q),
        .round_key   (rk[cnt_q]),
        .final_round (final_round),
        .next_state  (round_out)
    );

    // Next-state logic; round key 0 is always taken live at acceptance
    always_comb begin
        fsm_d = fsm_q;
        cnt_d = cnt_q;
        st_d  = st_q;
        ob_d  = ob_q;
        ov_d  = ov_q;
        case (fsm_q)
            IDLE: ;
            RUN: begin
                st_d = round_out;
                if (final_round) begin
                    ob_d  = round_out;
                    ov_d  = 1'b1;
                    fsm_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    ov_d  = 1'b0;
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        if (accept) begin
            fsm_d = RUN;
            cnt_d = CNT_W'(1);
            st_d  = in_block ^ round_keys[0:127];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
            st_q  <= '0;
            ob_q  <= '0;
            ov_q  <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            cnt_q <= cnt_d;
            st_q  <= st_d;
            ob_q  <= ob_d;
            ov_q  <= ov_d;
        end
    end

    assign out_valid = ov_q;
    assign out_block = ob_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: NK=4/6/8 instances checked every cycle against a byte-matrix AES model.
module tb_aes_cipher_iter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic          iv   [3];
    logic          ir   [3];
    logic [127:0]  ib   [3];
    logic [0:1919] rkv  [3];
    logic          ov   [3];
    logic          ordy [3];
    logic [127:0]  ob   [3];

    aes_cipher_iter #(.NK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_block(ib[0]),
        .round_keys(rkv[0][0:1407]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_block(ob[0]));
    aes_cipher_iter #(.NK(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_block(ib[1]),
        .round_keys(rkv[1][0:1663]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_block(ob[1]));
    aes_cipher_iter #(.NK(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_block(ib[2]),
        .round_keys(rkv[2][0:1919]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_block(ob[2]));

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] SEQ_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] SEQ_PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] SEQ_CT [3] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                           128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                                           128'h8ea2b7ca516745bfeafc49904b496089};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timed out", nm);
    endtask

    // ---------------- reference model (field arithmetic from first principles) ----------------
    logic [7:0] msbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int u = 1; u < 256; u++) begin
                if (gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            end
            msbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] t);
        return {msbox[t[31:24]], msbox[t[23:16]], msbox[t[15:8]], msbox[t[7:0]]};
    endfunction

    function automatic logic [0:1919] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1919] res;
        int            nr;
        nr  = nk + 6;
        rc  = 8'h01;
        res = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) res[128*r +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return res;
    endfunction

    function automatic logic [127:0] model_enc(input logic [127:0] pt, input logic [0:1919] rk, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] k;
        logic [127:0] res;
        k = rk[0:127];
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) s[i] = msbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++) t[4*c+row] = s[4*((c+row)%4)+row];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[4*c+row] = (r == nr) ? t[4*c+row] :
                                 gmul(8'h02, t[4*c+row]) ^ gmul(8'h03, t[4*c+(row+1)%4]) ^
                                 t[4*c+(row+2)%4] ^ t[4*c+(row+3)%4];
            k = rk[128*r +: 128];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- transaction-level expectation, checked every cycle ----------------
    bit           m_run  [3];
    int           m_rem  [3];
    bit           m_val  [3];
    logic [127:0] m_pend [3];
    logic [127:0] m_out  [3];

    initial begin
        logic exp_ir;
        logic acc;
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 1'b0; m_val[i] = 1'b0; m_rem[i] = 0;
            m_pend[i] = '0; m_out[i] = '0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    m_run[i] = 1'b0;
                    m_val[i] = 1'b0;
                end
                exp_ir = !m_run[i] && (!m_val[i] || ordy[i]);
                chk($sformatf("in_ready[%0d] @%0d", i, cyc), 128'(ir[i]), 128'(exp_ir));
                chk($sformatf("out_valid[%0d] @%0d", i, cyc), 128'(ov[i]), 128'(m_val[i]));
                if (m_val[i]) chk($sformatf("out_block[%0d] @%0d", i, cyc), ob[i], m_out[i]);
                if (!rst_n) begin
                    chk($sformatf("reset out_block[%0d]", i), ob[i], 128'h0);
                end else begin
                    acc = iv[i] && exp_ir;
                    if (m_run[i]) begin
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin
                            m_run[i] = 1'b0;
                            m_val[i] = 1'b1;
                            m_out[i] = m_pend[i];
                        end
                    end else if (m_val[i] && ordy[i]) begin
                        m_val[i] = 1'b0;
                    end
                    if (acc) begin
                        m_run[i]  = 1'b1;
                        m_rem[i]  = 10 + 2*i;
                        m_pend[i] = model_enc(ib[i], rkv[i], 10 + 2*i);
                    end
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic send(input int i, input logic [127:0] pt, input logic [0:1919] keys);
        int n;
        n = 0;
        ib[i] = pt; rkv[i] = keys; iv[i] = 1'b1;
        @(negedge clk);
        while (!ir[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now($sformatf("accept[%0d]", i));
        @(posedge clk);
        #2 iv[i] = 1'b0;
    endtask

    task automatic wait_out(input int i, input int exp_lat, input logic [127:0] exp, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (!ov[i] && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({nm, " latency"}, 128'(n), 128'(exp_lat));
        chk({nm, " block"}, ob[i], exp);
    endtask

    initial begin
        logic [0:1919] kf;
        logic [127:0]  held;
        int            c1;
        int            n;
        build_sbox();
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ib[i] = '0; rkv[i] = '0; ordy[i] = 1'b1;
        end
        kf = expand({FIPS_KEY, 128'h0}, 4);

        // Pin the model to the published vectors
        chk("model fips", model_enc(FIPS_PT, kf, 10), FIPS_CT);
        for (int i = 0; i < 3; i++)
            chk($sformatf("model seq nk%0d", 4 + 2*i),
                model_enc(SEQ_PT, expand(SEQ_KEY, 4 + 2*i), 10 + 2*i), SEQ_CT[i]);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset in_ready", 128'(ir[0]), 128'h1);
        chk("reset out_valid", 128'(ov[0]), 128'h0);
        chk("reset out_block", ob[0], 128'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        send(0, FIPS_PT, kf);
        wait_out(0, 10, FIPS_CT, "fips nk4");

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            send(i, SEQ_PT, expand(SEQ_KEY, 4 + 2*i));
            wait_out(i, 10 + 2*i, SEQ_CT[i], $sformatf("seq nk%0d", 4 + 2*i));
        end

        // Backpressure: output must hold while out_ready is low
        @(posedge clk);
        #2 ordy[0] = 1'b0;
        send(0, FIPS_PT, kf);
        wait_out(0, 10, FIPS_CT, "stall");
        held = ob[0];
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall hold block", ob[0], held);
            chk("stall in_ready", 128'(ir[0]), 128'h0);
            chk("stall out_valid", 128'(ov[0]), 128'h1);
        end
        @(posedge clk);
        #2 ordy[0] = 1'b1;
        @(negedge clk);
        chk("release in_ready", 128'(ir[0]), 128'h1);
        @(negedge clk);
        chk("release out_valid", 128'(ov[0]), 128'h0);
        chk("release idle in_ready", 128'(ir[0]), 128'h1);

        // Back-to-back: second block accepted in the first's DONE cycle
        @(posedge clk);
        #2;
        ib[0] = FIPS_PT; rkv[0] = kf; iv[0] = 1'b1;
        @(posedge clk);
        #2 ib[0] = SEQ_PT;
        n = 0;
        @(negedge clk);
        while (!ov[0] && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) fail_now("b2b first");
        c1 = int'(cyc);
        chk("b2b first block", ob[0], FIPS_CT);
        @(posedge clk);
        #2 iv[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!ov[0] && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) fail_now("b2b second");
        chk("b2b spacing", 128'(int'(cyc) - c1), 128'd11);
        chk("b2b second block", ob[0], model_enc(SEQ_PT, kf, 10));

        // Reset in the middle of a transaction
        @(posedge clk);
        #2;
        send(0, FIPS_PT, kf);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("midreset out_valid", 128'(ov[0]), 128'h0);
        chk("midreset in_ready", 128'(ir[0]), 128'h1);
        chk("midreset out_block", ob[0], 128'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        send(0, FIPS_PT, kf);
        wait_out(0, 10, FIPS_CT, "after reset");

`ifdef AES_KEY_REG_EN
        @(posedge clk);
        #2;
        send(0, FIPS_PT, kf);
        for (int w = 0; w < 44; w++) rkv[0][32*w +: 32] = $urandom();
        wait_out(0, 10, FIPS_CT, "keyreg scramble");
        rkv[0] = kf;
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
